mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter SHALL exist: TIMEOUT_CYC, 48, cycles waited for MPRODV before abort (used only when MULT_ARB_TIMEOUT_EN is defined).
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RST_N  in  1  reset, asynchronous and active-low.
REQ-004 REQ0 / REQ1  in  1  level request from port 0 / port 1; held until the matching RDY pulse.
REQ-005 SGN0 / SGN1  in  1  1 = signed multiply, 0 = unsigned, for port 0 / port 1.
REQ-006 A0, B0 / A1, B1  in  32  operands for port 0 / port 1.
REQ-007 RDY0 / RDY1  out  1  one-cycle pulse; RES is valid for that port in the same cycle.
REQ-008 RES  out  64  shared result bus.
REQ-009 ERR  out  1  high with RDYx when the operation was aborted; tied 0 without the macro.
REQ-010 BUSY  out  1  high in every state except IDLE.
REQ-011 MST, MSGN  out  1  start pulse and sign mode to the serial multiplier.
REQ-012 MSRCA, MSRCB  out  32  operands to the serial multiplier.
REQ-013 MRST  out  1  active-high synchronous reset to the serial multiplier.
REQ-014 MPROD  in  64, MPRODV  in  1  product and valid level from the serial multiplier.

Function
REQ-015 The FSM SHALL have the states INIT, IDLE, ISSUE, SETTLE, WAIT, DONE.
REQ-016 INIT SHALL drive MRST=1 for exactly one cycle and then go to IDLE.
REQ-017 In IDLE with any REQ high, the block SHALL grant one port, latch its SGN/A/B into internal registers, and go to ISSUE in the next cycle.
REQ-018 Arbitration SHALL be round-robin: if REQ0 and REQ1 are both high, the port not granted most recently wins; the pointer after reset favours port 0.
REQ-019 ISSUE SHALL assert MST=1 and MSGN for exactly one cycle.
REQ-020 MSRCA/MSRCB/MSGN SHALL stay stable from ISSUE until the exit from WAIT.
REQ-021 SETTLE SHALL last exactly 2 cycles and ignore MPRODV, which is stale from the previous product.
REQ-022 WAIT SHALL stay until MPRODV=1; on that edge RES<=MPROD and the FSM goes to DONE.
REQ-023 DONE SHALL pulse RDYx for the granted port for one cycle, update the round-robin pointer, and return to IDLE.
REQ-024 A new grant SHALL be made no earlier than the cycle after DONE; a REQ deasserted mid-operation SHALL NOT cancel it, and the RDY pulse still occurs.
REQ-025 RES SHALL hold its value until the next DONE.
REQ-026 MST SHALL never be asserted outside ISSUE; RDY0 and RDY1 SHALL never be high together.

Reset
REQ-027 While RST_N=0: FSM=INIT, RDY0=RDY1=0, ERR=0, MST=0, MSGN=0, MSRCA=MSRCB=0, RES=0, round-robin pointer favours port 0, BUSY=1, and MRST=1.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no RDY pulse; after release, INIT re-resets the multiplier.

Configuration
REQ-029 With MULT_ARB_TIMEOUT_EN defined, a counter SHALL run in SETTLE and WAIT. When it reaches TIMEOUT_CYC it SHALL assert MRST for 1 cycle, set RES=0, and pulse RDYx together with ERR=1.
REQ-030 Without MULT_ARB_TIMEOUT_EN, the block SHALL have no counter, WAIT SHALL be unbounded, and ERR SHALL be constant 0.

Verification
REQ-031 Release reset, then REQ0=1, SGN0=0, A0=3, B0=5 -> MRST pulses once after reset, MST one cycle, then RDY0 with RES=15, ERR=0.
REQ-032 REQ0 and REQ1 both high from IDLE, A0=2,B0=2 and A1=-3,B1=4 with SGN1=1 -> RDY0 first with RES=4, then RDY1 with RES=64'hFFFF_FFFF_FFFF_FFF4; a second simultaneous pair is served port 1 first.
REQ-033 Back-to-back requests with MPRODV still high from the previous product -> no early capture; RES equals the new product.
REQ-034 RST_N=0 during WAIT -> no RDY pulse, outputs at reset values; the next request completes correctly.
REQ-035 With MULT_ARB_TIMEOUT_EN defined and the multiplier model holding MPRODV=0 -> 48 cycles after entering SETTLE, MRST pulses and RDYx=1 with ERR=1, RES=0.

Source files
------------

// File: rtl/mult_arbiter.sv
// Two-port round-robin front end that shares one serial multiplier.
// Optional abort on a stalled multiplier is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
    parameter int TIMEOUT_CYC = 48
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        SGN0,
    input  logic        SGN1,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    output logic        RDY0,
    output logic        RDY1,
    output logic [63:0] RES,
    output logic        ERR,
    output logic        BUSY,
    output logic        MST,
    output logic        MSGN,
    output logic [31:0] MSRCA,
    output logic [31:0] MSRCB,
    output logic        MRST,
    input  logic [63:0] MPROD,
    input  logic        MPRODV,
    output logic [2:0]  DBG_STATE
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        settle_cnt;
    logic        grant;
    logic        grant_nxt;
    logic        rr_ptr;
    logic        sgn_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] res_q;
    logic        abort_take;
    logic        abort_q;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             in_flight;

    assign in_flight = (state == S_SETTLE) || (state == S_WAIT);
    // A product arriving on the very last cycle still wins over the abort.
    assign abort_take = in_flight && (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) &&
                        !((state == S_WAIT) && MPRODV);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt  <= '0;
            abort_q <= 1'b0;
        end else begin
            to_cnt  <= in_flight ? to_cnt + 1'b1 : '0;
            abort_q <= abort_take;
        end
    end
`else
    assign abort_take = 1'b0;
    assign abort_q    = 1'b0;
`endif

    // Both requesting: the pointer picks; otherwise whichever port asks.
    assign grant_nxt = (REQ0 && REQ1) ? rr_ptr : REQ1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_IDLE;
            S_IDLE:   if (REQ0 || REQ1) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (abort_take)      state_nxt = S_DONE;
                else if (settle_cnt) state_nxt = S_WAIT;
            end
            S_WAIT:   if (MPRODV || abort_take) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_INIT;
            settle_cnt <= 1'b0;
            grant      <= 1'b0;
            rr_ptr     <= 1'b0;
            sgn_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && (REQ0 || REQ1)) begin
                grant <= grant_nxt;
                sgn_q <= grant_nxt ? SGN1 : SGN0;
                a_q   <= grant_nxt ? A1 : A0;
                b_q   <= grant_nxt ? B1 : B0;
            end

            // MPRODV is stale for the two SETTLE cycles, so they are only counted.
            settle_cnt <= (state == S_SETTLE) ? ~settle_cnt : 1'b0;

            if (state == S_WAIT && MPRODV)
                res_q <= MPROD;
            else if (abort_take)
                res_q <= '0;

            if (state == S_DONE)
                rr_ptr <= ~grant;
        end
    end

    assign RDY0      = (state == S_DONE) && !grant;
    assign RDY1      = (state == S_DONE) && grant;
    assign RES       = res_q;
    assign ERR       = (state == S_DONE) && abort_q;
    assign BUSY      = (state != S_IDLE);
    assign MST       = (state == S_ISSUE);
    assign MSGN      = sgn_q;
    assign MSRCA     = a_q;
    assign MSRCB     = b_q;
    assign MRST      = (state == S_INIT) || ((state == S_DONE) && abort_q);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural serial multiplier whose
// valid flag stays high (stale) for two cycles after each new start.
module tb_mult_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, SGN0 = 1'b0, SGN1 = 1'b0;
    logic [31:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic        RDY0, RDY1, ERR, BUSY, MST, MSGN, MRST;
    logic [63:0] RES;
    logic [31:0] MSRCA, MSRCB;
    logic [63:0] MPROD;
    logic        MPRODV;
    logic [2:0]  DBG_STATE;

    int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
    int mst_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0, both_cnt = 0, mrst_cnt = 0;
    logic stall = 1'b0;

    mult_arbiter dut (
        .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .SGN0(SGN0), .SGN1(SGN1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .RDY0(RDY0), .RDY1(RDY1), .RES(RES),
        .ERR(ERR), .BUSY(BUSY), .MST(MST), .MSGN(MSGN), .MSRCA(MSRCA), .MSRCB(MSRCB),
        .MRST(MRST), .MPROD(MPROD), .MPRODV(MPRODV), .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    // Serial multiplier model: result 6 edges after the start, old valid dropped on the 2nd.
    logic [63:0] m_next;
    int          m_d;
    always @(posedge CLK) begin
        if (MRST) begin
            MPRODV <= 1'b0;
            MPROD  <= '0;
            m_d    <= 0;
        end else if (MST) begin
            m_d <= 6;
            if (MSGN)
                m_next <= {{32{MSRCA[31]}}, MSRCA} * {{32{MSRCB[31]}}, MSRCB};
            else
                m_next <= {32'd0, MSRCA} * {32'd0, MSRCB};
        end else if (m_d > 0) begin
            m_d <= m_d - 1;
            if (m_d == 5) MPRODV <= 1'b0;
            if (m_d == 1 && !stall) begin
                MPRODV <= 1'b1;
                MPROD  <= m_next;
            end
        end
    end

    always @(negedge CLK) begin
        if (MST)          mst_cnt++;
        if (RDY0)         rdy0_cnt++;
        if (RDY1)         rdy1_cnt++;
        if (RDY0 && RDY1) both_cnt++;
        if (MRST)         mrst_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy0"},  64'(RDY0),  64'd0);
        check({tag, "_rdy1"},  64'(RDY1),  64'd0);
        check({tag, "_err"},   64'(ERR),   64'd0);
        check({tag, "_mst"},   64'(MST),   64'd0);
        check({tag, "_msgn"},  64'(MSGN),  64'd0);
        check({tag, "_msrca"}, 64'(MSRCA), 64'd0);
        check({tag, "_msrcb"}, 64'(MSRCB), 64'd0);
        check({tag, "_res"},   RES,        64'd0);
        check({tag, "_busy"},  64'(BUSY),  64'd1);
        check({tag, "_mrst"},  64'(MRST),  64'd1);
    endtask

    // Release just after a rising edge so INIT lasts one full cycle.
    task automatic release_reset(input string tag);
        int m0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        m0 = mrst_cnt;
        repeat (4) @(posedge CLK);
        #1 check({tag, "_mrst_pulses"}, 64'(mrst_cnt - m0), 64'd1);
    endtask

    // Returns on the falling edge inside the DONE cycle.
    task automatic expect_rdy(input string tag, input logic port, input logic [63:0] exp_res,
                              input logic exp_err);
        logic        seen, r0, r1, err;
        logic [63:0] res;
        seen = 1'b0; r0 = 1'b0; r1 = 1'b0; err = 1'bx; res = 'x;
        for (int i = 0; i < 120 && !seen; i++) begin
            @(negedge CLK);
            if (RDY0 || RDY1) begin
                seen = 1'b1; r0 = RDY0; r1 = RDY1; res = RES; err = ERR;
            end
        end
        check({tag, "_port"}, {61'd0, seen, r1, r0}, {61'd0, 1'b1, port, ~port});
        check({tag, "_res"}, res, exp_res);
        check({tag, "_err"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        int mst0, rdy_sum;
        logic seen_mst;

        repeat (3) @(negedge CLK);
        check_reset("rst0");
        release_reset("rel0");

        // Single unsigned request on port 0.
        @(negedge CLK);
        REQ0 = 1'b1; SGN0 = 1'b0; A0 = 32'd3; B0 = 32'd5;
        mst0 = mst_cnt;
        expect_rdy("t031", 1'b0, 64'd15, 1'b0);
        REQ0 = 1'b0;
        check("t031_mst_once", 64'(mst_cnt - mst0), 64'd1);
        repeat (3) @(negedge CLK);
        check("t031_res_hold", RES, 64'd15);
        check("t031_idle", 64'(BUSY), 64'd0);

        @(negedge CLK);
        RST_N = 1'b0;
        #1 check_reset("rst1");
        repeat (2) @(negedge CLK);
        release_reset("rel1");

        // Simultaneous requests: pointer starts on port 0, then alternates.
        @(negedge CLK);
        REQ0 = 1'b1; SGN0 = 1'b0; A0 = 32'd2; B0 = 32'd2;
        REQ1 = 1'b1; SGN1 = 1'b1; A1 = -32'sd3; B1 = 32'd4;
        expect_rdy("t032a", 1'b0, 64'd4, 1'b0);
        SGN0 = 1'b1; A0 = 32'h8000_0000; B0 = 32'd2;
        expect_rdy("t032b", 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
        REQ1 = 1'b0;
        expect_rdy("t032c", 1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0);
        REQ0 = 1'b0;
        @(negedge CLK);
        REQ0 = 1'b1; SGN0 = 1'b0; A0 = 32'd100; B0 = 32'd100;
        REQ1 = 1'b1; SGN1 = 1'b1; A1 = -32'sd5; B1 = -32'sd6;
        expect_rdy("t032d", 1'b1, 64'd30, 1'b0);
        REQ1 = 1'b0;
        expect_rdy("t032e", 1'b0, 64'd10000, 1'b0);
        REQ0 = 1'b0;

        // Back-to-back on port 0 while the previous valid is still high.
        @(negedge CLK);
        REQ0 = 1'b1; SGN0 = 1'b0; A0 = 32'd1000; B0 = 32'd3;
        expect_rdy("t033a", 1'b0, 64'd3000, 1'b0);
        A0 = 32'hFFFF_FFFF; B0 = 32'd2;
        expect_rdy("t033b", 1'b0, 64'h1_FFFF_FFFE, 1'b0);
        SGN0 = 1'b1;
        expect_rdy("t033c", 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        REQ0 = 1'b0;

        // Reset during WAIT aborts silently; pointer returns to port 0.
        @(negedge CLK);
        REQ0 = 1'b1; SGN0 = 1'b0; A0 = 32'd7; B0 = 32'd9;
        seen_mst = 1'b0;
        for (int i = 0; i < 20 && !seen_mst; i++) begin
            @(negedge CLK);
            if (MST) seen_mst = 1'b1;
        end
        check("t034_mst_seen", 64'(seen_mst), 64'd1);
        repeat (4) @(negedge CLK);
        check("t034_msrca_stable", 64'(MSRCA), 64'd7);
        check("t034_msrcb_stable", 64'(MSRCB), 64'd9);
        check("t034_busy", 64'(BUSY), 64'd1);
        rdy_sum = rdy0_cnt + rdy1_cnt;
        RST_N = 1'b0;
        #1 check_reset("t034_rst");
        A0 = 32'd11; B0 = 32'd13;
        REQ1 = 1'b1; SGN1 = 1'b0; A1 = 32'd6; B1 = 32'd7;
        repeat (3) @(negedge CLK);
        release_reset("t034_rel");
        check("t034_no_rdy", 64'(rdy0_cnt + rdy1_cnt - rdy_sum), 64'd0);
        expect_rdy("t034a", 1'b0, 64'd143, 1'b0);
        REQ0 = 1'b0;
        expect_rdy("t034b", 1'b1, 64'd42, 1'b0);
        REQ1 = 1'b0;

        repeat (2) @(negedge CLK);
        check("never_both_rdy", 64'(both_cnt), 64'd0);
        check("mst_total", 64'(mst_cnt), 64'd12);
        check("rdy0_total", 64'(rdy0_cnt), 64'd8);
        check("rdy1_total", 64'(rdy1_cnt), 64'd3);

`ifdef MULT_ARB_TIMEOUT_EN
        stall = 1'b1;
        @(negedge CLK);
        REQ0 = 1'b1; SGN0 = 1'b0; A0 = 32'd5; B0 = 32'd5;
        expect_rdy("t035", 1'b0, 64'd0, 1'b1);
        check("t035_mrst", 64'(MRST), 64'd1);
        stall = 1'b0;
        expect_rdy("t035_recover", 1'b0, 64'd25, 1'b0);
        REQ0 = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
